core_lsu: RTL and testbench
===========================

// Module: core_lsu
// PURPOSE
//  Memory-side responder for the MEM-stage controls (mem_read, mem_write, read_type, write_type).
//  Turns one load/store per instruction into a single 64-bit aligned bus transaction.
//  Generates byte strobes and lane-replicated write data, checks alignment, and sign/zero-extends load data.
//  Stalls the pipeline until the access completes, faults, or times out.
// PARAMETERS
//  XLEN        64   data/address width; bus is XLEN wide, XLEN/8 byte lanes
//  TIMEOUT     255  max cycles in REQ+RESP before bus_err_o; counter width $clog2(TIMEOUT+1)
// PORTS
//  clk           in   1     clock, all state on posedge
//  rst           in   1     synchronous, active-high reset
//  mem_read_i    in   1     load request; held stable while stall_o=1
//  mem_write_i   in   1     store request; held stable while stall_o=1
//  read_type_i   in   3     funct3: 0 LB,1 LH,2 LW,3 LD,4 LBU,5 LHU,6 LWU,7 illegal
//  write_type_i  in   2     funct3[1:0]: 0 SB,1 SH,2 SW,3 SD
//  addr_i        in   XLEN  effective byte address
//  wdata_i       in   XLEN  store data, right-justified
//  stall_o       out  1     (mem_read_i|mem_write_i) & ~done_o, combinational
//  done_o        out  1     one-cycle pulse: access finished (ok or fault)
//  rdata_o       out  XLEN  extended load data, valid with done_o, held until next load done
//  misalign_o    out  1     with done_o: misaligned or illegal type, no bus access made
//  bus_err_o     out  1     with done_o: bus_err_i seen or timeout
//  bus_req_o     out  1     request, held until bus_gnt_i
//  bus_we_o      out  1     1=write
//  bus_addr_o    out  XLEN  {addr_i[XLEN-1:3],3'b0}
//  bus_wdata_o   out  XLEN  lane-replicated store data
//  bus_wstrb_o   out  8     byte strobes (0 for reads)
//  bus_gnt_i     in   1     request accepted this cycle
//  bus_rvalid_i  in   1     response (read data or write ack)
//  bus_rdata_i   in   XLEN  read data, full 8-byte word
//  bus_err_i     in   1     response error, qualified by bus_rvalid_i
// BEHAVIOUR
//  Reset: state IDLE, all outputs 0, timeout counter 0.
//  FSM IDLE->REQ->RESP->DONE->IDLE. Latched at IDLE exit: op, type, addr[2:0], replicated wdata, strobes.
//  IDLE: if mem_write_i|mem_read_i (write wins if both): misaligned/illegal -> DONE, misalign set; else -> REQ.
//  Alignment: H needs addr[0]=0, W addr[1:0]=0, D addr[2:0]=0; B always ok.
//  REQ: bus_req_o=1, bus_* held constant; bus_gnt_i -> RESP. bus_rvalid_i in the gnt cycle is legal and taken.
//  RESP: bus_req_o=0; bus_rvalid_i -> DONE; latch bus_err_i into bus_err_o.
//  Load: lane = bus_rdata_i >> (8*addr[2:0]); sign-extend from bit 7/15/31 (types 0/1/2), zero-extend (types 4/5/6).
//  Store strobes: SB 8'h01<<a, SH 8'h03<<a, SW 8'h0F<<a, SD 8'hFF (a=addr[2:0]).
//  Store data: byte x8, half x4, word x2, dword as is.
//  Timeout: counter clears on IDLE exit, +1 each REQ/RESP cycle; reaching TIMEOUT -> DONE with bus_err_o=1.
//   bus_req_o drops. A late rvalid after that is ignored.
//  DONE: done_o=1 for exactly one cycle, then IDLE. rdata_o is not updated on store, fault, or error.
//  Min latency, aligned, gnt+rvalid same cycle: request seen cycle 0, done_o cycle 2.
//  bus_rvalid_i/bus_gnt_i outside REQ/RESP are ignored.
//  Reset mid-access: IDLE next cycle, bus_req_o=0, no done_o; pending response ignored.
// TESTING
//  1 SD addr 0x1000 wdata 0x1122334455667788, gnt cycle1, rvalid cycle3
//    -> bus_addr 0x1000, wstrb 0xFF, done_o cycle4 only, stall_o low cycle4.
//  2 LB addr 0x1003, bus_rdata 0x00000000_80000000 -> rdata_o 0xFFFFFFFFFFFFFF80;
//    same with LBU -> 0x80; LWU addr 0x1004, rdata 0xDEADBEEF_00000000 -> 0xDEADBEEF.
//  3 SH addr 0x2006 wdata 0xBEEF -> bus_addr 0x2000, wstrb 0xC0, wdata 0xBEEFBEEFBEEFBEEF.
//  4 LW addr 0x1002; LD addr 0x1004; read_type 7
//    -> misalign_o=1 with done_o at cycle1, bus_req_o never asserted.
//  5 gnt withheld forever, TIMEOUT=8 -> bus_err_o+done_o after 8 wait cycles, bus_req_o drops.
//    Then rvalid with bus_err_i=1 on a load -> bus_err_o=1, rdata_o unchanged.
//  6 rst in RESP, then rvalid -> no done_o, state IDLE.
//    Next LD addr 0x0 with rdata 0x0123456789ABCDEF completes normally -> rdata_o 0x0123456789ABCDEF.

Source files
------------

// File: rtl/core_lsu_if.sv
// Data-memory bus between the load/store unit (master) and memory (slave).
// One request per access, answered by a single response beat.
interface core_lsu_if #(
    parameter int unsigned XLEN = 64
);
    localparam int unsigned NB = XLEN / 8;

    logic            bus_req_o;
    logic            bus_we_o;
    logic [XLEN-1:0] bus_addr_o;
    logic [XLEN-1:0] bus_wdata_o;
    logic [NB-1:0]   bus_wstrb_o;
    logic            bus_gnt_i;
    logic            bus_rvalid_i;
    logic [XLEN-1:0] bus_rdata_i;
    logic            bus_err_i;

    modport master (
        output bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_wstrb_o,
        input  bus_gnt_i, bus_rvalid_i, bus_rdata_i, bus_err_i
    );

    modport slave (
        input  bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_wstrb_o,
        output bus_gnt_i, bus_rvalid_i, bus_rdata_i, bus_err_i
    );
endinterface

// File: rtl/core_lsu.sv
// MEM-stage load/store unit: one aligned bus transaction per load/store, with
// strobe/lane generation, alignment checking, load extension and a bus timeout.
module core_lsu #(
    parameter int unsigned XLEN    = 64,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mem_read_i,
    input  logic            mem_write_i,
    input  logic [2:0]      read_type_i,
    input  logic [1:0]      write_type_i,
    input  logic [XLEN-1:0] addr_i,
    input  logic [XLEN-1:0] wdata_i,
    output logic            stall_o,
    output logic            done_o,
    output logic [XLEN-1:0] rdata_o,
    output logic            misalign_o,
    output logic            bus_err_o,
    core_lsu_if.master      bus
);
    localparam int unsigned NB   = XLEN / 8;
    localparam int unsigned OFFW = $clog2(NB);
    localparam int unsigned CNTW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          r_state,     w_nxt_state;
    logic [CNTW-1:0] r_cnt,       w_nxt_cnt;
    logic            r_is_wr,     w_nxt_is_wr;
    logic [2:0]      r_type,      w_nxt_type;
    logic [OFFW-1:0] r_off,       w_nxt_off;
    logic            r_bus_req,   w_nxt_bus_req;
    logic            r_bus_we,    w_nxt_bus_we;
    logic [XLEN-1:0] r_bus_addr,  w_nxt_bus_addr;
    logic [XLEN-1:0] r_bus_wdata, w_nxt_bus_wdata;
    logic [NB-1:0]   r_bus_wstrb, w_nxt_bus_wstrb;
    logic            r_done,      w_nxt_done;
    logic            r_misalign,  w_nxt_misalign;
    logic            r_bus_err,   w_nxt_bus_err;
    logic [XLEN-1:0] r_rdata,     w_nxt_rdata;

    logic [1:0]      w_size;
    logic [OFFW-1:0] w_off;
    logic [OFFW-1:0] w_align_mask;
    logic            w_misalign;
    logic [NB-1:0]   w_strb_base;
    logic [NB-1:0]   w_wstrb;
    logic [XLEN-1:0] w_wdata_rep;
    logic [XLEN-1:0] w_lane;
    logic [XLEN-1:0] w_load_ext;
    logic [CNTW-1:0] w_cnt_inc;
    logic            w_timeout;
    logic            w_finish;

    // Request decode: access size, alignment, strobes and replicated store data
    assign w_size = mem_write_i ? write_type_i : read_type_i[1:0];
    assign w_off  = addr_i[OFFW-1:0];

    always_comb begin
        w_align_mask = '0;
        w_strb_base  = '0;
        w_wdata_rep  = wdata_i;
        case (w_size)
            2'd0: begin
                w_align_mask = '0;
                w_strb_base  = NB'(1);
                w_wdata_rep  = {NB{wdata_i[7:0]}};
            end
            2'd1: begin
                w_align_mask = OFFW'(1);
                w_strb_base  = NB'(3);
                w_wdata_rep  = {(NB/2){wdata_i[15:0]}};
            end
            2'd2: begin
                w_align_mask = OFFW'(3);
                w_strb_base  = NB'(15);
                w_wdata_rep  = {(NB/4){wdata_i[31:0]}};
            end
            default: begin
                w_align_mask = '1;
                w_strb_base  = '1;
                w_wdata_rep  = wdata_i;
            end
        endcase
    end

    // Type 7 is only illegal as a load; a store always uses a legal 2-bit size
    assign w_misalign = (|(w_off & w_align_mask)) |
                        (~mem_write_i & (read_type_i == 3'd7));
    assign w_wstrb    = w_strb_base << w_off;

    // Load path: bring the addressed lane down to bit 0, then extend
    assign w_lane = bus.bus_rdata_i >> {r_off, 3'b000};

    always_comb begin
        w_load_ext = w_lane;
        case (r_type)
            3'd0:    w_load_ext = {{(XLEN-8){w_lane[7]}},   w_lane[7:0]};
            3'd1:    w_load_ext = {{(XLEN-16){w_lane[15]}}, w_lane[15:0]};
            3'd2:    w_load_ext = {{(XLEN-32){w_lane[31]}}, w_lane[31:0]};
            3'd4:    w_load_ext = {{(XLEN-8){1'b0}},        w_lane[7:0]};
            3'd5:    w_load_ext = {{(XLEN-16){1'b0}},       w_lane[15:0]};
            3'd6:    w_load_ext = {{(XLEN-32){1'b0}},       w_lane[31:0]};
            default: w_load_ext = w_lane;
        endcase
    end

    assign w_cnt_inc = r_cnt + CNTW'(1);
    assign w_timeout = (w_cnt_inc == CNTW'(TIMEOUT));

    // Next-state and next-output logic
    always_comb begin
        w_nxt_state     = r_state;
        w_nxt_cnt       = r_cnt;
        w_nxt_is_wr     = r_is_wr;
        w_nxt_type      = r_type;
        w_nxt_off       = r_off;
        w_nxt_bus_req   = 1'b0;
        w_nxt_bus_we    = r_bus_we;
        w_nxt_bus_addr  = r_bus_addr;
        w_nxt_bus_wdata = r_bus_wdata;
        w_nxt_bus_wstrb = r_bus_wstrb;
        w_nxt_done      = 1'b0;
        w_nxt_misalign  = 1'b0;
        w_nxt_bus_err   = 1'b0;
        w_nxt_rdata     = r_rdata;
        w_finish        = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (mem_write_i | mem_read_i) begin
                    w_nxt_cnt       = '0;
                    w_nxt_is_wr     = mem_write_i;
                    w_nxt_type      = mem_write_i ? {1'b0, write_type_i} : read_type_i;
                    w_nxt_off       = w_off;
                    w_nxt_bus_we    = mem_write_i;
                    w_nxt_bus_addr  = {addr_i[XLEN-1:OFFW], OFFW'(0)};
                    w_nxt_bus_wdata = mem_write_i ? w_wdata_rep : '0;
                    w_nxt_bus_wstrb = mem_write_i ? w_wstrb : '0;
                    if (w_misalign) begin
                        w_nxt_state    = S_DONE;
                        w_nxt_done     = 1'b1;
                        w_nxt_misalign = 1'b1;
                    end else begin
                        w_nxt_state   = S_REQ;
                        w_nxt_bus_req = 1'b1;
                    end
                end
            end
            S_REQ: begin
                w_nxt_cnt = w_cnt_inc;
                // A response in the grant cycle completes the access outright
                if (bus.bus_gnt_i && bus.bus_rvalid_i) begin
                    w_finish = 1'b1;
                end else if (w_timeout) begin
                    w_nxt_state   = S_DONE;
                    w_nxt_done    = 1'b1;
                    w_nxt_bus_err = 1'b1;
                end else if (bus.bus_gnt_i) begin
                    w_nxt_state = S_RESP;
                end else begin
                    w_nxt_bus_req = 1'b1;
                end
            end
            S_RESP: begin
                w_nxt_cnt = w_cnt_inc;
                if (bus.bus_rvalid_i) begin
                    w_finish = 1'b1;
                end else if (w_timeout) begin
                    w_nxt_state   = S_DONE;
                    w_nxt_done    = 1'b1;
                    w_nxt_bus_err = 1'b1;
                end
            end
            S_DONE: begin
                w_nxt_state = S_IDLE;
            end
            default: begin
                w_nxt_state = S_IDLE;
            end
        endcase

        if (w_finish) begin
            w_nxt_state   = S_DONE;
            w_nxt_done    = 1'b1;
            w_nxt_bus_err = bus.bus_err_i;
            if (!r_is_wr && !bus.bus_err_i) begin
                w_nxt_rdata = w_load_ext;
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_is_wr     <= 1'b0;
            r_type      <= '0;
            r_off       <= '0;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_bus_wstrb <= '0;
            r_done      <= 1'b0;
            r_misalign  <= 1'b0;
            r_bus_err   <= 1'b0;
            r_rdata     <= '0;
        end else begin
            r_state     <= w_nxt_state;
            r_cnt       <= w_nxt_cnt;
            r_is_wr     <= w_nxt_is_wr;
            r_type      <= w_nxt_type;
            r_off       <= w_nxt_off;
            r_bus_req   <= w_nxt_bus_req;
            r_bus_we    <= w_nxt_bus_we;
            r_bus_addr  <= w_nxt_bus_addr;
            r_bus_wdata <= w_nxt_bus_wdata;
            r_bus_wstrb <= w_nxt_bus_wstrb;
            r_done      <= w_nxt_done;
            r_misalign  <= w_nxt_misalign;
            r_bus_err   <= w_nxt_bus_err;
            r_rdata     <= w_nxt_rdata;
        end
    end

    assign stall_o    = (mem_read_i | mem_write_i) & ~r_done;
    assign done_o     = r_done;
    assign rdata_o    = r_rdata;
    assign misalign_o = r_misalign;
    assign bus_err_o  = r_bus_err;

    assign bus.bus_req_o   = r_bus_req;
    assign bus.bus_we_o    = r_bus_we;
    assign bus.bus_addr_o  = r_bus_addr;
    assign bus.bus_wdata_o = r_bus_wdata;
    assign bus.bus_wstrb_o = r_bus_wstrb;
endmodule

// File: tb/tb_core_lsu.sv
// Bench for core_lsu: directed vector table, reset/late-response sequences,
// and randomized accesses against a behavioural model of the access rules.
module tb_core_lsu;
    localparam int unsigned XLEN  = 64;
    localparam int          TMO   = 8;
    localparam int          NEVER = 99;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read_i;
    logic        mem_write_i;
    logic [2:0]  read_type_i;
    logic [1:0]  write_type_i;
    logic [63:0] addr_i;
    logic [63:0] wdata_i;
    logic        stall_o;
    logic        done_o;
    logic [63:0] rdata_o;
    logic        misalign_o;
    logic        bus_err_o;

    core_lsu_if #(.XLEN(XLEN)) bus_if ();

    core_lsu #(.XLEN(XLEN), .TIMEOUT(TMO)) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_read_i   (mem_read_i),
        .mem_write_i  (mem_write_i),
        .read_type_i  (read_type_i),
        .write_type_i (write_type_i),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .stall_o      (stall_o),
        .done_o       (done_o),
        .rdata_o      (rdata_o),
        .misalign_o   (misalign_o),
        .bus_err_o    (bus_err_o),
        .bus          (bus_if)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
    endtask

    // Observations from the most recent access
    int          ob_done;
    int          ob_reqc;
    logic [63:0] ob_addr, ob_wdata, ob_rdata, ob_gap_rdata;
    logic [7:0]  ob_wstrb;
    logic        ob_we, ob_mis, ob_err, ob_stall_done, ob_req_done;
    logic        ob_stall_hold, ob_gap_done, ob_gap_req, ob_gap_stall;

    // Issue one access at cycle 0 (called at a negedge); the bus answers gnt at cycle g, rvalid at cycle r
    task automatic run_op(input logic wr, input logic rd, input logic [2:0] rt, input logic [1:0] wt,
                          input logic [63:0] a, input logic [63:0] wd, input int g, input int r,
                          input logic [63:0] brd, input logic berr);
        ob_done = -1; ob_reqc = 0; ob_stall_hold = 1'b1;
        ob_addr = '0; ob_wdata = '0; ob_wstrb = '0; ob_we = 1'b0;
        ob_mis = 1'b0; ob_err = 1'b0; ob_rdata = '0; ob_stall_done = 1'b1; ob_req_done = 1'b1;
        mem_write_i = wr; mem_read_i = rd; read_type_i = rt; write_type_i = wt;
        addr_i = a; wdata_i = wd;
        bus_if.bus_rdata_i = brd; bus_if.bus_err_i = berr;
        bus_if.bus_gnt_i = 1'b0; bus_if.bus_rvalid_i = 1'b0;
        for (int c = 1; c <= 40 && ob_done < 0; c++) begin
            @(negedge clk);
            if (done_o) begin
                ob_done = c; ob_mis = misalign_o; ob_err = bus_err_o; ob_rdata = rdata_o;
                ob_stall_done = stall_o; ob_req_done = bus_if.bus_req_o;
            end else begin
                if (!stall_o) ob_stall_hold = 1'b0;
                if (bus_if.bus_req_o) begin
                    if (ob_reqc == 0) begin
                        ob_addr = bus_if.bus_addr_o; ob_we = bus_if.bus_we_o;
                        ob_wstrb = bus_if.bus_wstrb_o; ob_wdata = bus_if.bus_wdata_o;
                    end
                    ob_reqc++;
                end
                bus_if.bus_gnt_i    = (c == g);
                bus_if.bus_rvalid_i = (c == r);
            end
        end
        if (ob_done < 0) $display("FAIL op_budget: got no done_o within 40 cycles, expected done_o");
        // Stray handshakes in the DONE cycle must be ignored
        mem_write_i = 1'b0; mem_read_i = 1'b0;
        bus_if.bus_gnt_i = 1'b1; bus_if.bus_rvalid_i = 1'b1; bus_if.bus_rdata_i = ~brd;
        @(negedge clk);
        ob_gap_done = done_o; ob_gap_req = bus_if.bus_req_o;
        ob_gap_stall = stall_o; ob_gap_rdata = rdata_o;
        bus_if.bus_gnt_i = 1'b0; bus_if.bus_rvalid_i = 1'b0;
    endtask

    task automatic check_obs(input string tag, input int e_done, input logic e_mis, input logic e_err,
                             input int e_reqc, input logic [63:0] e_addr, input logic e_we,
                             input logic [7:0] e_strb, input logic [63:0] e_wdata,
                             input logic [63:0] e_rdata);
        chk({tag, ".done_cycle"}, 64'(ob_done), 64'(e_done));
        chk({tag, ".misalign"},   64'(ob_mis), 64'(e_mis));
        chk({tag, ".bus_err"},    64'(ob_err), 64'(e_err));
        chk({tag, ".req_cycles"}, 64'(ob_reqc), 64'(e_reqc));
        chk({tag, ".stall_at_done"}, 64'(ob_stall_done), 64'd0);
        chk({tag, ".req_at_done"},   64'(ob_req_done), 64'd0);
        chk({tag, ".stall_before"},  64'(ob_stall_hold), 64'd1);
        chk({tag, ".done_pulse"},    64'(ob_gap_done), 64'd0);
        chk({tag, ".gap_req"},       64'(ob_gap_req), 64'd0);
        chk({tag, ".gap_stall"},     64'(ob_gap_stall), 64'd0);
        chk({tag, ".rdata"},         ob_rdata, e_rdata);
        chk({tag, ".rdata_hold"},    ob_gap_rdata, e_rdata);
        if (e_reqc > 0) begin
            chk({tag, ".bus_addr"}, ob_addr, e_addr);
            chk({tag, ".bus_we"},   64'(ob_we), 64'(e_we));
            chk({tag, ".bus_wstrb"}, 64'(ob_wstrb), 64'(e_strb));
            if (e_we) chk({tag, ".bus_wdata"}, ob_wdata, e_wdata);
        end
    endtask

    // Behavioural model of the access rules
    function automatic logic [63:0] m_load(input logic [2:0] rt, input logic [63:0] word, input int off);
        int nb;
        logic [63:0] v, mask;
        nb   = 1 << rt[1:0];
        v    = word >> (8 * off);
        mask = (nb == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * nb)) - 64'd1);
        v    = v & mask;
        if (!rt[2] && v[8*nb-1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic [7:0] m_strb(input int nb, input int off);
        logic [7:0] s;
        s = '0;
        for (int i = 0; i < 8; i++) s[i] = (i >= off) && (i < off + nb);
        return s;
    endfunction

    function automatic logic [63:0] m_wdata(input int nb, input logic [63:0] wd);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < 8; i++) v[8*i +: 8] = wd[8*(i % nb) +: 8];
        return v;
    endfunction

    typedef struct {
        logic        wr;
        logic [2:0]  rt;
        logic [1:0]  wt;
        logic [63:0] a;
        logic [63:0] wd;
        int          g;
        int          r;
        logic [63:0] brd;
        logic        berr;
        int          e_done;
        logic        e_mis;
        logic        e_err;
        int          e_reqc;
        logic [63:0] e_addr;
        logic [7:0]  e_strb;
        logic [63:0] e_wdata;
        logic [63:0] e_rdata;
    } vec_t;

    vec_t vt[17];
    logic [63:0] exp_rdata;

    initial begin
        //          wr  rt    wt    addr          wdata                  g      r      bus_rdata              err   done mis  err  reqc addr          strb    wdata                  rdata
        vt[0]  = '{1'b1, 3'd0, 2'd3, 64'h1000, 64'h1122334455667788, 1, 3, 64'h0, 1'b0, 4, 1'b0, 1'b0, 1, 64'h1000, 8'hFF, 64'h1122334455667788, 64'h0};
        vt[1]  = '{1'b0, 3'd0, 2'd0, 64'h1003, 64'h0, 1, 1, 64'h0000000080000000, 1'b0, 2, 1'b0, 1'b0, 1, 64'h1000, 8'h00, 64'h0, 64'hFFFFFFFFFFFFFF80};
        vt[2]  = '{1'b0, 3'd4, 2'd0, 64'h1003, 64'h0, 1, 1, 64'h0000000080000000, 1'b0, 2, 1'b0, 1'b0, 1, 64'h1000, 8'h00, 64'h0, 64'h80};
        vt[3]  = '{1'b0, 3'd6, 2'd0, 64'h1004, 64'h0, 2, 4, 64'hDEADBEEF00000000, 1'b0, 5, 1'b0, 1'b0, 2, 64'h1000, 8'h00, 64'h0, 64'hDEADBEEF};
        vt[4]  = '{1'b1, 3'd0, 2'd1, 64'h2006, 64'hBEEF, 1, 1, 64'h0, 1'b0, 2, 1'b0, 1'b0, 1, 64'h2000, 8'hC0, 64'hBEEFBEEFBEEFBEEF, 64'hDEADBEEF};
        vt[5]  = '{1'b0, 3'd2, 2'd0, 64'h1002, 64'h0, 1, 1, 64'h0, 1'b0, 1, 1'b1, 1'b0, 0, 64'h0, 8'h00, 64'h0, 64'hDEADBEEF};
        vt[6]  = '{1'b0, 3'd3, 2'd0, 64'h1004, 64'h0, 1, 1, 64'h0, 1'b0, 1, 1'b1, 1'b0, 0, 64'h0, 8'h00, 64'h0, 64'hDEADBEEF};
        vt[7]  = '{1'b0, 3'd7, 2'd0, 64'h1000, 64'h0, 1, 1, 64'h0, 1'b0, 1, 1'b1, 1'b0, 0, 64'h0, 8'h00, 64'h0, 64'hDEADBEEF};
        vt[8]  = '{1'b0, 3'd1, 2'd0, 64'h3002, 64'h0, 1, 2, 64'h0000000080010000, 1'b0, 3, 1'b0, 1'b0, 1, 64'h3000, 8'h00, 64'h0, 64'hFFFFFFFFFFFF8001};
        vt[9]  = '{1'b1, 3'd0, 2'd2, 64'h14, 64'hFFFFFFFF12345678, 3, 3, 64'h0, 1'b0, 4, 1'b0, 1'b0, 3, 64'h10, 8'hF0, 64'h1234567812345678, 64'hFFFFFFFFFFFF8001};
        vt[10] = '{1'b1, 3'd0, 2'd0, 64'h7, 64'h12A5, 1, 1, 64'h0, 1'b0, 2, 1'b0, 1'b0, 1, 64'h0, 8'h80, 64'hA5A5A5A5A5A5A5A5, 64'hFFFFFFFFFFFF8001};
        vt[11] = '{1'b0, 3'd3, 2'd0, 64'h0, 64'h0, 1, 1, 64'h0123456789ABCDEF, 1'b0, 2, 1'b0, 1'b0, 1, 64'h0, 8'h00, 64'h0, 64'h0123456789ABCDEF};
        vt[12] = '{1'b0, 3'd2, 2'd0, 64'h40, 64'h0, NEVER, NEVER, 64'h5555, 1'b0, TMO+1, 1'b0, 1'b1, TMO, 64'h40, 8'h00, 64'h0, 64'h0123456789ABCDEF};
        vt[13] = '{1'b0, 3'd3, 2'd0, 64'h8, 64'h0, 1, 2, 64'hFFFFFFFFFFFFFFFF, 1'b1, 3, 1'b0, 1'b1, 1, 64'h8, 8'h00, 64'h0, 64'h0123456789ABCDEF};
        vt[14] = '{1'b1, 3'd0, 2'd1, 64'h2001, 64'h1234, 1, 1, 64'h0, 1'b0, 1, 1'b1, 1'b0, 0, 64'h0, 8'h00, 64'h0, 64'h0123456789ABCDEF};
        vt[15] = '{1'b1, 3'd0, 2'd3, 64'h18, 64'hCAFEF00D12345678, 2, NEVER, 64'h0, 1'b0, TMO+1, 1'b0, 1'b1, 2, 64'h18, 8'hFF, 64'hCAFEF00D12345678, 64'h0123456789ABCDEF};
        vt[16] = '{1'b0, 3'd5, 2'd0, 64'h22, 64'h0, TMO, TMO, 64'h00000000F00D0000, 1'b0, TMO+1, 1'b0, 1'b0, TMO, 64'h20, 8'h00, 64'h0, 64'hF00D};

        rst = 1'b1;
        mem_read_i = 1'b0; mem_write_i = 1'b0; read_type_i = '0; write_type_i = '0;
        addr_i = '0; wdata_i = '0;
        bus_if.bus_gnt_i = 1'b0; bus_if.bus_rvalid_i = 1'b0;
        bus_if.bus_rdata_i = '0; bus_if.bus_err_i = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst.done",     64'(done_o), 64'd0);
        chk("rst.stall",    64'(stall_o), 64'd0);
        chk("rst.rdata",    rdata_o, 64'd0);
        chk("rst.misalign", 64'(misalign_o), 64'd0);
        chk("rst.bus_err",  64'(bus_err_o), 64'd0);
        chk("rst.bus_req",  64'(bus_if.bus_req_o), 64'd0);
        chk("rst.bus_we",   64'(bus_if.bus_we_o), 64'd0);
        chk("rst.bus_addr", bus_if.bus_addr_o, 64'd0);
        chk("rst.bus_wdata", bus_if.bus_wdata_o, 64'd0);
        chk("rst.bus_wstrb", 64'(bus_if.bus_wstrb_o), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed vector table
        for (int i = 0; i < 17; i++) begin
            run_op(vt[i].wr, ~vt[i].wr, vt[i].rt, vt[i].wt, vt[i].a, vt[i].wd,
                   vt[i].g, vt[i].r, vt[i].brd, vt[i].berr);
            check_obs($sformatf("vec%0d", i), vt[i].e_done, vt[i].e_mis, vt[i].e_err, vt[i].e_reqc,
                      vt[i].e_addr, vt[i].wr, vt[i].e_strb, vt[i].e_wdata, vt[i].e_rdata);
        end

        // Reset while waiting for the response, then a stale response arrives
        mem_read_i = 1'b1; read_type_i = 3'd2; addr_i = 64'h20;
        bus_if.bus_rdata_i = 64'hAAAA_BBBB_CCCC_DDDD; bus_if.bus_err_i = 1'b0;
        @(negedge clk);
        chk("rstmid.req_c1", 64'(bus_if.bus_req_o), 64'd1);
        bus_if.bus_gnt_i = 1'b1;
        @(negedge clk);
        chk("rstmid.req_c2", 64'(bus_if.bus_req_o), 64'd0);
        chk("rstmid.done_c2", 64'(done_o), 64'd0);
        bus_if.bus_gnt_i = 1'b0; rst = 1'b1; mem_read_i = 1'b0;
        @(negedge clk);
        rst = 1'b0; bus_if.bus_rvalid_i = 1'b1;
        chk("rstmid.req_c3", 64'(bus_if.bus_req_o), 64'd0);
        chk("rstmid.done_c3", 64'(done_o), 64'd0);
        chk("rstmid.rdata_c3", rdata_o, 64'd0);
        @(negedge clk);
        bus_if.bus_rvalid_i = 1'b0;
        chk("rstmid.done_c4", 64'(done_o), 64'd0);
        chk("rstmid.req_c4", 64'(bus_if.bus_req_o), 64'd0);
        @(negedge clk);
        chk("rstmid.done_c5", 64'(done_o), 64'd0);
        run_op(1'b0, 1'b1, 3'd3, 2'd0, 64'h0, 64'h0, 1, 1, 64'h0123456789ABCDEF, 1'b0);
        check_obs("rstmid.ld", 2, 1'b0, 1'b0, 1, 64'h0, 1'b0, 8'h00, 64'h0, 64'h0123456789ABCDEF);
        exp_rdata = 64'h0123456789ABCDEF;

        // Randomized accesses against the model
        for (int k = 0; k < 150; k++) begin
            logic        wr, rd, berr, mis, tmo, e_err;
            logic [2:0]  rt;
            logic [1:0]  wt;
            logic [63:0] a, wd, brd;
            int          g, r, nb, off, e_done, e_reqc;
            wr   = 1'($urandom_range(0, 1));
            rd   = wr ? 1'($urandom_range(0, 1)) : 1'b1;
            rt   = 3'($urandom_range(0, 7));
            wt   = 2'($urandom_range(0, 3));
            nb   = 1 << (wr ? int'(wt) : int'(rt[1:0]));
            a    = {$urandom, $urandom};
            if ($urandom_range(0, 3) != 0) a = a & ~64'(nb - 1);
            wd   = {$urandom, $urandom};
            brd  = {$urandom, $urandom};
            berr = ($urandom_range(0, 7) == 0);
            g    = $urandom_range(1, 10);
            r    = g + $urandom_range(0, 3);
            off  = int'(a[2:0]);
            mis  = ((off % nb) != 0) || (!wr && rt == 3'd7);
            tmo  = !(g <= TMO && r <= TMO);
            if (mis) begin
                e_done = 1; e_reqc = 0; e_err = 1'b0;
            end else if (!tmo) begin
                e_done = r + 1; e_reqc = g; e_err = berr;
            end else begin
                e_done = TMO + 1; e_reqc = (g <= TMO) ? g : TMO; e_err = 1'b1;
            end
            if (!mis && !wr && !e_err) exp_rdata = m_load(rt, brd, off);
            run_op(wr, rd, rt, wt, a, wd, g, r, brd, berr);
            check_obs($sformatf("rnd%0d", k), e_done, mis, e_err, e_reqc, {a[63:3], 3'b000}, wr,
                      wr ? m_strb(nb, off) : 8'h00, m_wdata(nb, wd), exp_rdata);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
